// File: rtl/btn_conditioner.sv
// Multi-channel push-button front end: 2-flop sync, counter debounce,
// press/release pulses and optional hold-to-repeat fire pulses per channel.

module btn_chan #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 40_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000,
  parameter int CNT_W           = 26
) (
  input  logic CLK,
  input  logic nRST,
  input  logic raw_i,
  input  logic rep_en_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic fire_o
);
  typedef enum logic [1:0] {IDLE, HOLD, DELAY, REPEAT} state_e;

  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_MAX  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_MAX  = CNT_W'(REPEAT_PERIOD - 1);

  logic             s1_q, s2_q;
  logic             level_q, level_d;
  logic             press_q, press_d, rel_q, rel_d, fire_q, fire_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d, rcnt_q, rcnt_d;
  state_e           state_q, state_d;

  // Any cycle where s2 agrees with the accepted level restarts the count.
  always_comb begin
    dcnt_d  = '0;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (s2_q != level_q) begin
      if (dcnt_q == DEB_MAX) begin
        level_d = ~level_q;
        press_d = ~level_q;
        rel_d   = level_q;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    fire_d  = 1'b0;
    case (state_q)
      IDLE: if (press_d) begin
        fire_d  = 1'b1;
        rcnt_d  = '0;
        state_d = rep_en_i ? DELAY : HOLD;
      end
      HOLD: if (rel_d) state_d = IDLE;
      DELAY: begin
        // Release takes priority over a coinciding repeat tick.
        if (rel_d) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == RD_MAX) begin
          fire_d  = 1'b1;
          rcnt_d  = '0;
          state_d = REPEAT;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      REPEAT: begin
        if (rel_d) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == RP_MAX) begin
          fire_d = 1'b1;
          rcnt_d = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      fire_q  <= 1'b0;
      dcnt_q  <= '0;
      rcnt_q  <= '0;
      state_q <= IDLE;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      fire_q  <= fire_d;
      dcnt_q  <= dcnt_d;
      rcnt_q  <= rcnt_d;
      state_q <= state_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign fire_o    = fire_q;
endmodule

module btn_conditioner #(
  parameter int N_CH            = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 40_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000,
  parameter int CNT_W           = 26
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [N_CH-1:0] btn_raw,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_fire
);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .CNT_W          (CNT_W)
    ) u_ch (
      .CLK      (CLK),
      .nRST     (nRST),
      .raw_i    (btn_raw[i]),
      .rep_en_i (repeat_en[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i]),
      .fire_o   (btn_fire[i])
    );
  end
endmodule
